// File: rtl/shift_pkg.sv
// Shared definitions for the serial receive path: FSM state encoding and
// the bit-counter sizing helper.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // Bits needed to count 0..width-1, never less than one.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Right-shifting capture register: new bits enter at the MSB so that the
// first bit of an LSB-first stream lands in bit 0 once the word is full.
module sipo_shreg
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr) begin
      sh_d = '0;
    end else if (en) begin
      sh_d = {sin, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q = sh_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: start arms one frame of WIDTH LSB-first
// bits, gated by enable; completed words are held until acknowledged.
module sipo_rx
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             enable,
  input  logic             sin,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] word;
  logic             sh_clr;
  logic             sh_en;
  logic             done;

  sipo_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sh_clr),
    .en   (sh_en),
    .sin  (sin),
    .q    (sh_q)
  );

  // The completing bit is folded in here so the word is captured on the
  // same edge that the last bit is sampled.
  assign word = {sin, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        // A restart wins over a completing bit in the same cycle.
        if (start) begin
          cnt_d  = '0;
          sh_clr = 1'b1;
        end else if (enable) begin
          sh_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (done) begin
      if (!valid_q || ack_i) begin
        data_d  = word;
        valid_d = 1'b1;
        if (valid_q) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ack_i) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == SHIFT);
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: a frame-level model predicts visible words
// and flags; a negedge monitor checks data_o against the expected queue.
module tb_sipo_rx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         enable = 1'b0;
  logic         sin = 1'b0;
  logic         ack_i = 1'b0;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         busy_o;
  logic         overrun_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  bit           m_busy;
  bit           m_valid;
  bit           m_ovr;
  bit           m_bits[$];

  sipo_rx #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .enable   (enable),
    .sin      (sin),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ack_i    (ack_i),
    .busy_o   (busy_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whenever a word is presented it must be the oldest expected one;
  // an accepted handshake retires it.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL data_o: valid_o=1 with no expected word, got 0x%0h at %0t", data_o, $time);
      end else begin
        chk("data_o", data_o, exp_q[0]);
        if (ack_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit s, input bit e, input bit b, input bit a);
    bit           done;
    logic [W-1:0] w;
    start  = s;
    enable = e;
    sin    = b;
    ack_i  = a;
    @(posedge clk);
    done = m_busy && e && !s && (m_bits.size() == W - 1);
    w    = '0;
    if (s) begin
      m_busy = 1'b1;
      m_bits.delete();
    end else if (m_busy && e) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
        m_busy = 1'b0;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid) begin
        exp_q.push_back(w);
        m_valid = 1'b1;
      end else if (a) begin
        exp_q.push_back(w);
        m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (a && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    #1;
    chk("busy_o", busy_o, m_busy);
    chk("valid_o", valid_o, m_valid);
    chk("overrun_o", overrun_o, m_ovr);
  endtask

  task automatic frame(input logic [W-1:0] wd, input int gmax, input bit rack, input bit ack_last);
    step(1'b1, rb(), rb(), rack ? rb() : 1'b0);
    for (int i = 0; i < W; i++) begin
      int g;
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) step(1'b0, 1'b0, rb(), rack ? rb() : 1'b0);
      step(1'b0, 1'b1, wd[i], (i == W - 1) ? ack_last : (rack ? rb() : 1'b0));
    end
  endtask

  task automatic partial(input int n);
    step(1'b1, rb(), rb(), 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rb(), 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_o"}, data_o, '0);
    chk({tag, "_valid_o"}, valid_o, 1'b0);
    chk({tag, "_busy_o"}, busy_o, 1'b0);
    chk({tag, "_overrun_o"}, overrun_o, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_bits.delete();
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_init");
    @(negedge clk);
    #1 rst_n = 1'b1;

    frame(16'hA5C3, 0, 1'b0, 1'b0);
    chk("a5c3_data", data_o, 16'hA5C3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    frame(16'hA5C3, 3, 1'b0, 1'b0);
    chk("a5c3_gap_data", data_o, 16'hA5C3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    frame(16'h1234, 1, 1'b0, 1'b0);
    frame(16'hFFFF, 0, 1'b0, 1'b0);
    chk("drop_data", data_o, 16'h1234);
    chk("drop_ovr", overrun_o, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drop_ack_valid", valid_o, 1'b0);
    chk("drop_ack_ovr", overrun_o, 1'b0);

    frame(16'h1234, 0, 1'b0, 1'b0);
    frame(16'h00FF, 0, 1'b0, 1'b1);
    chk("coinc_data", data_o, 16'h00FF);
    chk("coinc_valid", valid_o, 1'b1);
    chk("coinc_ovr", overrun_o, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    partial(7);
    frame(16'hBEEF, 0, 1'b0, 1'b0);
    chk("abort_data", data_o, 16'hBEEF);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    partial(W - 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_last_valid", valid_o, 1'b0);
    frame(16'h5A0F, 2, 1'b0, 1'b0);
    chk("after_abort_data", data_o, 16'h5A0F);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    partial(9);
    do_reset();
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, rb(), 1'b0);
    chk("nostart_valid", valid_o, 1'b0);

    repeat (40) begin
      if ($urandom_range(3, 0) == 0) partial(int'($urandom_range(W - 1, 0)));
      frame(W'($urandom), int'($urandom_range(3, 0)), 1'b1, rb());
      repeat ($urandom_range(4, 0)) step(1'b0, rb(), rb(), rb());
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the word length in bits; legal range 2..64.
REQ-002 The block SHALL have localparam CW, default $clog2(WIDTH), meaning the bit-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: frame-start pulse that arms reception of one word.
REQ-006 The block SHALL have port enable, input, 1 bit: bit strobe; sin is sampled only when enable=1.
REQ-007 The block SHALL have port sin, input, 1 bit: serial data, LSB first, as driven by the team's right-shift transmitter.
REQ-008 The block SHALL have port data_o, output, WIDTH bits: last completed word.
REQ-009 The block SHALL have port valid_o, output, 1 bit: data_o holds an unconsumed word.
REQ-010 The block SHALL have port ack_i, input, 1 bit: consumer accepts data_o; meaningful only while valid_o=1.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high while in SHIFT state.
REQ-012 The block SHALL have port overrun_o, output, 1 bit: sticky flag, a completed word was dropped.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 In IDLE, enable SHALL be ignored; start=1 SHALL go to SHIFT, clear the bit counter and the shift register.
REQ-015 The start cycle SHALL NOT sample sin, even if enable=1; the first bit is taken on the next enable.
REQ-016 In SHIFT with enable=1, shreg SHALL become {sin, shreg[WIDTH-1:1]} and the counter SHALL increment by 1.
REQ-017 In SHIFT with enable=0, shreg and counter SHALL hold.
REQ-018 On the enable with counter=WIDTH-1, the word SHALL complete and the state SHALL return to IDLE; the first received bit ends up in bit 0.
REQ-019 On completion with valid_o=0, data_o SHALL take the completed word and valid_o SHALL be 1 from the next cycle (one-cycle latency after the last enable).
REQ-020 On completion with valid_o=1 and ack_i=1 in the same cycle, the new word SHALL replace data_o and valid_o SHALL stay 1; overrun_o SHALL NOT be set.
REQ-021 On completion with valid_o=1 and ack_i=0, the new word SHALL be dropped, data_o SHALL be unchanged, and overrun_o SHALL be set.
REQ-022 ack_i=1 with valid_o=1 and no completion SHALL clear valid_o next cycle; data_o SHALL keep its value.
REQ-023 overrun_o SHALL clear on the first accepted ack_i that is not itself coincident with a drop.
REQ-024 start=1 in SHIFT SHALL abort the current frame, discard partial bits and restart at counter=0, even if that cycle would complete the word; the restart takes priority and no word is produced.
REQ-025 ack_i while valid_o=0 SHALL have no effect.
REQ-026 The counter SHALL never exceed WIDTH-1; no wrap-around occurs in SHIFT.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, force state=IDLE, counter=0, shreg=0, data_o=0, valid_o=0, busy_o=0, overrun_o=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word; after release, reception needs a fresh start.
REQ-029 Deassertion SHALL be synchronous to clk at the integration level; the block adds no synchronizer.

Structure
REQ-030 The state encoding enum (IDLE, SHIFT) SHALL live in shared package shift_pkg, together with a function giving the counter width for a given WIDTH.
REQ-031 The shift register SHALL be a sub-module sipo_shreg (params WIDTH; ports clk, rst_n, clr, en, sin, q); the FSM, counter and output handshake SHALL stay in sipo_rx.
REQ-032 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Verification
REQ-033 WIDTH=16: start, then 16 enables carrying the LSB-first bits of 0xA5C3 -> one cycle after the 16th enable, data_o=0xA5C3, valid_o=1, busy_o=0.
REQ-034 Same frame with enable=0 gaps of 0..3 cycles between bits -> data_o=0xA5C3; busy_o=1 throughout the gaps.
REQ-035 Word 0x1234 pending (no ack), then a second frame of 0xFFFF completes -> data_o=0x1234, overrun_o=1; a later ack -> valid_o=0, overrun_o=0.
REQ-036 Ack coincident with completion of 0x00FF while 0x1234 is pending -> data_o=0x00FF, valid_o stays 1, overrun_o=0.
REQ-037 start re-asserted after 7 bits, then 16 bits of 0xBEEF -> data_o=0xBEEF; the partial bits never appear on data_o.
REQ-038 rst_n pulsed low after 9 bits -> all outputs 0 immediately; 16 enables without start -> valid_o stays 0.
